// File: rtl/palm_pkg.sv
// ---------------------------------------------------------------------------
// palm_pkg
// Shared definitions for the palm scan controller:
//   IMG_W, IMG_H  - default frame geometry in pixels / lines
//   WDOG_CYCLES   - default idle-pixel timeout in clocks (used only when the
//                   design is built with PALM_SCAN_WATCHDOG_EN)
//   state_t       - controller FSM state encoding
// ---------------------------------------------------------------------------
package palm_pkg;

    localparam int IMG_W       = 160;
    localparam int IMG_H       = 120;
    localparam int WDOG_CYCLES = 4096;

    // IDLE is encoded as zero so the debug state output reads 0 in reset.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_WAIT_SOF = 3'd2,
        ST_SCAN     = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/palm_pixel_counter.sv
// ---------------------------------------------------------------------------
// palm_pixel_counter
// Row/column tracker for the pixel stream.
//   clk, rst   - clock, asynchronous active-low reset
//   clear      - the pixel in this cycle is (0,0)
//   inc        - a pixel is accepted in this cycle
//   row, col   - coordinates of the pixel in this cycle
//   last       - the pixel accepted in this cycle is (IMG_H-1, IMG_W-1)
// The registers hold the coordinate of the next pixel to arrive; row/col
// are therefore combinational so the accepted pixel sees its own position.
// clear together with inc means "this pixel is the origin", so the stored
// position advances to (0,1).
// ---------------------------------------------------------------------------
module palm_pixel_counter #(
    parameter int IMG_W = palm_pkg::IMG_W,
    parameter int IMG_H = palm_pkg::IMG_H
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       inc,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic       last
);

    localparam logic [7:0] COL_MAX = 8'(IMG_W - 1);
    localparam logic [7:0] ROW_MAX = 8'(IMG_H - 1);

    logic [7:0] r_row;
    logic [7:0] r_col;
    logic [7:0] w_row_base;
    logic [7:0] w_col_base;
    logic [7:0] w_row_nxt;
    logic [7:0] w_col_nxt;

    always_comb begin
        w_row_base = clear ? 8'd0 : r_row;
        w_col_base = clear ? 8'd0 : r_col;
        w_row_nxt  = w_row_base;
        w_col_nxt  = w_col_base;
        if (inc) begin
            if (w_col_base == COL_MAX) begin
                w_col_nxt = 8'd0;
                w_row_nxt = (w_row_base == ROW_MAX) ? 8'd0 : w_row_base + 8'd1;
            end else begin
                w_col_nxt = w_col_base + 8'd1;
            end
        end
    end

    assign row  = w_row_base;
    assign col  = w_col_base;
    assign last = inc & (w_row_base == ROW_MAX) & (w_col_base == COL_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= 8'd0;
            r_col <= 8'd0;
        end else begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
        end
    end

endmodule

// File: rtl/palm_scan_controller.sv
// ---------------------------------------------------------------------------
// palm_scan_controller
// Sequences one palm capture: clears the identification datapath, waits
// for start of frame, streams pixels with coordinates into the datapath and
// returns the detected palm geometry (or a not-found / timeout status).
//
// Optional feature: define PALM_SCAN_WATCHDOG_EN to add an idle-pixel
// watchdog that ends the capture with res_timeout=1 after WDOG_CYCLES
// consecutive clocks without pix_valid in WAIT_SOF/SCAN. Without it,
// res_timeout is tied to 0 and the controller waits indefinitely.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   start                    - capture request (honoured in IDLE only)
//   sof, pix_valid, pix_obj  - segmented pixel stream
//   pid_found/width/height   - palm detection result from the datapath
//   pid_clear                - one-cycle datapath clear
//   pid_en                   - pixel accept enable to the datapath
//   pid_obj                  - pix_obj forwarded, gated by pid_en
//   pix_row, pix_col         - coordinates of the pixel in this cycle
//   res_valid/res_ready      - result handshake
//   res_found, res_timeout   - result status
//   res_width, res_height    - latched palm geometry
//   busy                     - state is not IDLE
//   dbg_state                - current FSM state
//
// Result handshake: res_valid is high for the whole DONE state and all
// res_* outputs are held stable while it is high; a transfer happens on a
// rising edge where res_valid & res_ready, after which res_valid drops.
// ---------------------------------------------------------------------------
module palm_scan_controller #(
    parameter int IMG_W       = palm_pkg::IMG_W,
    parameter int IMG_H       = palm_pkg::IMG_H,
    parameter int WDOG_CYCLES = palm_pkg::WDOG_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sof,
    input  logic       pix_valid,
    input  logic       pix_obj,
    input  logic       pid_found,
    input  logic [7:0] pid_width,
    input  logic [7:0] pid_height,
    output logic       pid_clear,
    output logic       pid_en,
    output logic       pid_obj,
    output logic [7:0] pix_row,
    output logic [7:0] pix_col,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_found,
    output logic       res_timeout,
    output logic [7:0] res_width,
    output logic [7:0] res_height,
    output logic       busy,
    output logic [2:0] dbg_state
);

    import palm_pkg::*;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_res_found;
    logic [7:0] r_res_width;
    logic [7:0] r_res_height;
    logic       w_res_found_nxt;
    logic [7:0] w_res_width_nxt;
    logic [7:0] w_res_height_nxt;

    logic       w_pix_start;
    logic       w_cnt_clear;
    logic       w_cnt_inc;
    logic       w_last;
    logic       w_wdog_hit;

    assign w_pix_start = sof & pix_valid;

`ifdef PALM_SCAN_WATCHDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);

    logic           r_res_timeout;
    logic           w_res_timeout_nxt;
    logic [WDW-1:0] r_wdog_cnt;
    logic           w_wdog_active;

    assign w_wdog_active = (r_state == ST_WAIT_SOF) || (r_state == ST_SCAN);
    // Fires on the WDOG_CYCLES-th consecutive idle clock.
    assign w_wdog_hit    = w_wdog_active & ~pix_valid &
                           (r_wdog_cnt == WDW'(WDOG_CYCLES - 1));

    // Outside WAIT_SOF/SCAN the counter sits at zero, which gives the clear
    // on state entry; the WAIT_SOF->SCAN step always carries a pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog_cnt <= '0;
        end else if (!w_wdog_active || pix_valid) begin
            r_wdog_cnt <= '0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end

    assign res_timeout = r_res_timeout;
`else
    assign w_wdog_hit  = 1'b0;
    assign res_timeout = 1'b0;
`endif

    palm_pixel_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pixel_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (w_cnt_clear),
        .inc   (w_cnt_inc),
        .row   (pix_row),
        .col   (pix_col),
        .last  (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_res_found  <= 1'b0;
            r_res_width  <= 8'd0;
            r_res_height <= 8'd0;
`ifdef PALM_SCAN_WATCHDOG_EN
            r_res_timeout <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_res_found  <= w_res_found_nxt;
            r_res_width  <= w_res_width_nxt;
            r_res_height <= w_res_height_nxt;
`ifdef PALM_SCAN_WATCHDOG_EN
            r_res_timeout <= w_res_timeout_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_res_found_nxt  = r_res_found;
        w_res_width_nxt  = r_res_width;
        w_res_height_nxt = r_res_height;
`ifdef PALM_SCAN_WATCHDOG_EN
        w_res_timeout_nxt = r_res_timeout;
`endif
        pid_clear   = 1'b0;
        pid_en      = 1'b0;
        w_cnt_clear = 1'b0;
        w_cnt_inc   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ARM;
                end
            end

            ST_ARM: begin
                pid_clear        = 1'b1;
                w_cnt_clear      = 1'b1;
                w_res_found_nxt  = 1'b0;
                w_res_width_nxt  = 8'd0;
                w_res_height_nxt = 8'd0;
`ifdef PALM_SCAN_WATCHDOG_EN
                w_res_timeout_nxt = 1'b0;
`endif
                w_state_nxt      = ST_WAIT_SOF;
            end

            ST_WAIT_SOF: begin
                if (w_pix_start) begin
                    // Frame entry pixel is (0,0) and goes to the datapath.
                    w_cnt_clear = 1'b1;
                    w_cnt_inc   = 1'b1;
                    pid_en      = 1'b1;
                    w_state_nxt = ST_SCAN;
                end else if (w_wdog_hit) begin
                    w_res_found_nxt = 1'b0;
`ifdef PALM_SCAN_WATCHDOG_EN
                    w_res_timeout_nxt = 1'b1;
`endif
                    w_state_nxt     = ST_DONE;
                end
            end

            ST_SCAN: begin
                if (w_pix_start) begin
                    // Resync: the datapath is cleared in this cycle, so the
                    // new origin pixel is withheld from it.
                    pid_clear   = 1'b1;
                    w_cnt_clear = 1'b1;
                    w_cnt_inc   = 1'b1;
                end else if (pix_valid) begin
                    pid_en    = 1'b1;
                    w_cnt_inc = 1'b1;
                end

                // Priority: detection, then end of frame, then watchdog.
                if (pid_found) begin
                    w_res_found_nxt  = 1'b1;
                    w_res_width_nxt  = pid_width;
                    w_res_height_nxt = pid_height;
                    w_state_nxt      = ST_DONE;
                end else if (w_last) begin
                    w_res_found_nxt  = 1'b0;
                    w_res_width_nxt  = 8'd0;
                    w_res_height_nxt = 8'd0;
                    w_state_nxt      = ST_DONE;
                end else if (w_wdog_hit) begin
                    w_res_found_nxt  = 1'b0;
                    w_res_width_nxt  = 8'd0;
                    w_res_height_nxt = 8'd0;
`ifdef PALM_SCAN_WATCHDOG_EN
                    w_res_timeout_nxt = 1'b1;
`endif
                    w_state_nxt      = ST_DONE;
                end
            end

            ST_DONE: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Gated so the datapath only sees object bits of accepted pixels.
    assign pid_obj    = pix_obj & pid_en;
    assign res_valid  = (r_state == ST_DONE);
    assign res_found  = r_res_found;
    assign res_width  = r_res_width;
    assign res_height = r_res_height;
    assign busy       = (r_state != ST_IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_palm_scan_controller.sv
module tb_palm_scan_controller;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int WD = 16;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sof;
    logic       pix_valid;
    logic       pix_obj;
    logic       pid_found;
    logic [7:0] pid_width;
    logic [7:0] pid_height;
    logic       pid_clear;
    logic       pid_en;
    logic       pid_obj;
    logic [7:0] pix_row;
    logic [7:0] pix_col;
    logic       res_valid;
    logic       res_ready;
    logic       res_found;
    logic       res_timeout;
    logic [7:0] res_width;
    logic [7:0] res_height;
    logic       busy;
    logic [2:0] dbg_state;

    palm_scan_controller #(
        .IMG_W       (W),
        .IMG_H       (H),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sof         (sof),
        .pix_valid   (pix_valid),
        .pix_obj     (pix_obj),
        .pid_found   (pid_found),
        .pid_width   (pid_width),
        .pid_height  (pid_height),
        .pid_clear   (pid_clear),
        .pid_en      (pid_en),
        .pid_obj     (pid_obj),
        .pix_row     (pix_row),
        .pix_col     (pix_col),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_found   (res_found),
        .res_timeout (res_timeout),
        .res_width   (res_width),
        .res_height  (res_height),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Capture phase, index of the next pixel in the frame (row-major),
    // consecutive idle clocks, and the queue of results still owed.
    typedef enum int {M_IDLE, M_ARM, M_WAIT, M_SCAN, M_DONE} mph_t;
    mph_t        m_ph;
    int          m_pidx;
    int          m_idle;
    logic [17:0] exp_q[$];

    function automatic void m_finish(input logic f, input logic t,
                                     input logic [7:0] w, input logic [7:0] h);
        exp_q.push_back({f, t, w, h});
        m_ph = M_DONE;
    endfunction

    function automatic void m_idle_tick();
        if (pix_valid) begin
            m_idle = 0;
        end else begin
`ifdef PALM_SCAN_WATCHDOG_EN
            m_idle++;
            if (m_idle == WD) m_finish(1'b0, 1'b1, 8'd0, 8'd0);
`endif
        end
    endfunction

    function automatic void m_step();
        case (m_ph)
            M_IDLE: if (start) m_ph = M_ARM;
            M_ARM: begin
                m_ph   = M_WAIT;
                m_idle = 0;
            end
            M_WAIT: begin
                if (sof && pix_valid) begin
                    m_ph   = M_SCAN;
                    m_pidx = 1;
                    m_idle = 0;
                end else begin
                    m_idle_tick();
                end
            end
            M_SCAN: begin
                if (pid_found) begin
                    m_finish(1'b1, 1'b0, pid_width, pid_height);
                end else if (pix_valid) begin
                    m_idle = 0;
                    if (sof) m_pidx = 1;
                    else if (m_pidx == W * H - 1) m_finish(1'b0, 1'b0, 8'd0, 8'd0);
                    else m_pidx++;
                end else begin
                    m_idle_tick();
                end
            end
            M_DONE: begin
                if (res_ready) begin
                    void'(exp_q.pop_front());
                    m_ph = M_IDLE;
                end
            end
            default: m_ph = M_IDLE;
        endcase
    endfunction

    task automatic compare_outputs();
        logic e_start;
        logic e_clear;
        logic e_en;
        int   idx;
        e_start = sof & pix_valid;
        e_clear = (m_ph == M_ARM) || (m_ph == M_SCAN && e_start);
        e_en    = (m_ph == M_WAIT && e_start) || (m_ph == M_SCAN && pix_valid && !sof);
        check("busy", 32'(busy), 32'(m_ph != M_IDLE));
        check("res_valid", 32'(res_valid), 32'(m_ph == M_DONE));
        check("pid_clear", 32'(pid_clear), 32'(e_clear));
        check("pid_en", 32'(pid_en), 32'(e_en));
        check("pid_obj", 32'(pid_obj), 32'(pix_obj & e_en));
        if ((m_ph == M_SCAN && pix_valid) || (m_ph == M_WAIT && e_start)) begin
            idx = e_start ? 0 : m_pidx;
            check("pix_row", 32'(pix_row), 32'(idx / W));
            check("pix_col", 32'(pix_col), 32'(idx % W));
        end
        if (m_ph == M_DONE) begin
            if (exp_q.size() == 0) begin
                check("result_expected", 32'(0), 32'(1));
            end else begin
                check("res_found", 32'(res_found), 32'(exp_q[0][17]));
                check("res_timeout", 32'(res_timeout), 32'(exp_q[0][16]));
                check("res_width", 32'(res_width), 32'(exp_q[0][15:8]));
                check("res_height", 32'(res_height), 32'(exp_q[0][7:0]));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic st, input logic sf, input logic pv, input logic obj,
                         input logic fnd, input logic [7:0] w, input logic [7:0] h,
                         input logic rdy);
        start      = st;
        sof        = sf;
        pix_valid  = pv;
        pix_obj    = obj;
        pid_found  = fnd;
        pid_width  = w;
        pid_height = h;
        res_ready  = rdy;
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
              1'b0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pid_clear"}, 32'(pid_clear), 32'(0));
        check({tag, "_pid_en"}, 32'(pid_en), 32'(0));
        check({tag, "_pid_obj"}, 32'(pid_obj), 32'(0));
        check({tag, "_pix_row"}, 32'(pix_row), 32'(0));
        check({tag, "_pix_col"}, 32'(pix_col), 32'(0));
        check({tag, "_res_valid"}, 32'(res_valid), 32'(0));
        check({tag, "_res_found"}, 32'(res_found), 32'(0));
        check({tag, "_res_timeout"}, 32'(res_timeout), 32'(0));
        check({tag, "_res_width"}, 32'(res_width), 32'(0));
        check({tag, "_res_height"}, 32'(res_height), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_dbg_state"}, 32'(dbg_state), 32'(0));
    endtask

    // Asserts reset between clock edges with the stream still active and
    // checks that the outputs drop before any clock edge arrives.
    task automatic async_reset();
        pix_valid = 1'b1;
        pix_obj   = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        m_ph   = M_IDLE;
        m_pidx = 0;
        m_idle = 0;
        exp_q.delete();
        start = 1'b0; sof = 1'b0; pix_valid = 1'b0; pix_obj = 1'b0;
        pid_found = 1'b0; pid_width = 8'd0; pid_height = 8'd0; res_ready = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        rst = 1'b1;
    endtask

    // One capture. Negative indices disable the corresponding event.
    task automatic run_frame(input int found_at, input int resync_at, input int stall_at,
                             input int stall_len, input int gap_max, input int rdy_delay,
                             input int abort_at, input bit abort_done,
                             input logic [7:0] fw, input logic [7:0] fh);
        int   budget;
        bit   resynced;
        int   stall_left;
        logic rs;
        logic fnd;
        budget     = 40000;
        resynced   = 1'b0;
        stall_left = stall_len;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1,
              8'hAA, 8'h55, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'd0, 8'd0, 1'b0);
        while (m_ph == M_SCAN && budget > 0) begin
            budget--;
            if (m_pidx == abort_at) begin
                async_reset();
                return;
            end
            if (m_pidx == stall_at && stall_left > 0) begin
                repeat (stall_left) drive_idle();
                stall_left = 0;
                continue;
            end
            repeat ($urandom_range(0, gap_max)) drive_idle();
            rs  = !resynced && (m_pidx == resync_at);
            fnd = (m_pidx == found_at) && !rs && (resync_at < 0 || resynced);
            drive(1'($urandom_range(0, 1)), rs, 1'b1, 1'($urandom_range(0, 1)), fnd,
                  fw, fh, 1'($urandom_range(0, 1)));
            if (rs) resynced = 1'b1;
        end
        if (budget == 0) check("frame_budget", 32'(0), 32'(1));
        if (m_ph == M_DONE) begin
            repeat (rdy_delay) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
            if (abort_done) begin
                async_reset();
                return;
            end
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0;
        start = 1'b0; sof = 1'b0; pix_valid = 1'b0; pix_obj = 1'b0;
        pid_found = 1'b0; pid_width = 8'd0; pid_height = 8'd0; res_ready = 1'b0;
        m_ph = M_IDLE; m_pidx = 0; m_idle = 0;
        #3;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) drive_idle();

        // Palm at row 10 / col 40, result held 5 cycles before ready.
        run_frame(10 * W + 40, -1, -1, 0, 0, 5, -1, 1'b0, 8'd24, 8'd36);
        // Full frame without detection.
        run_frame(-1, -1, -1, 0, 0, 2, -1, 1'b0, 8'd0, 8'd0);
        // Detection on the very last pixel: found wins.
        run_frame(W * H - 1, -1, -1, 0, 0, 0, -1, 1'b0, 8'd77, 8'd99);
        // Resync at row 50, then detection in the new frame.
        run_frame(200, 50 * W + 17, -1, 0, 1, 1, -1, 1'b0, 8'd12, 8'd34);
        // Stream stall of WD+4 idle clocks mid-scan.
        run_frame(500, -1, 300, WD + 4, 1, 1, -1, 1'b0, 8'd5, 8'd6);
        // Reset in the middle of SCAN, then no result must appear.
        run_frame(1000, -1, -1, 0, 1, 0, 400, 1'b0, 8'd1, 8'd2);
        repeat (5) drive_idle();
        // Reset while a result waits in DONE.
        run_frame(30, -1, -1, 0, 0, 3, -1, 1'b1, 8'd9, 8'd8);
        repeat (5) drive_idle();
        // Randomized captures.
        for (int k = 0; k < 4; k++) begin
            run_frame($urandom_range(1, 1500), -1, -1, 0, 2, $urandom_range(0, 4), -1, 1'b0,
                      8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
        end
        repeat (3) drive_idle();
        check("results_outstanding", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/palm_scan_controller.md
PALM_SCAN_CONTROLLER -- requirements
Module: palm_scan_controller

Interface
REQ-001 Parameters SHALL be: IMG_W default 160, frame width in pixels; IMG_H default 120, frame height in lines; WDOG_CYCLES default 4096, idle-pixel timeout in clocks.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request one palm capture; honoured only in IDLE.
REQ-005 sof  in  1  start of frame; valid only when pix_valid=1.
REQ-006 pix_valid  in  1  pixel strobe from segmentation.
REQ-007 pix_obj  in  1  segmented object bit; forwarded to the datapath.
REQ-008 pid_found  in  1  palm detected by the palm-identification datapath.
REQ-009 pid_width, pid_height  in  8 each  palm geometry from the datapath; valid with pid_found.
REQ-010 pid_clear  out  1  one-cycle pulse that clears the datapath.
REQ-011 pid_en  out  1  pixel-accept enable to the datapath.
REQ-012 pix_row, pix_col  out  8 each  coordinates of the current pixel.
REQ-013 res_valid / res_ready  out / in  1 each  result handshake.
REQ-014 res_found, res_timeout  out  1 each  result status flags.
REQ-015 res_width, res_height  out  8 each  latched palm geometry.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ARM, WAIT_SOF, SCAN and DONE.
REQ-018 IDLE->ARM on start; ARM lasts exactly 1 cycle, asserts pid_clear and then goes to WAIT_SOF.
REQ-019 WAIT_SOF->SCAN on (sof & pix_valid); that pixel is row 0, col 0 and is forwarded; sof without pix_valid is ignored.
REQ-020 pid_en SHALL equal pix_valid while in SCAN (including the entry pixel), else 0; pix_obj is passed through combinationally.
REQ-021 pix_col counts 0..IMG_W-1 per accepted pixel and wraps to 0 with pix_row+1; pix_row counts 0..IMG_H-1.
REQ-022 pid_found in SCAN SHALL latch pid_width/pid_height into res_*, set res_found=1, and go to DONE; res_valid rises on the next cycle.
REQ-023 Accepting pixel (IMG_H-1, IMG_W-1) without pid_found SHALL go to DONE with res_found=0 and res_width/res_height=0.
REQ-024 pid_found and the last pixel in the same cycle: found wins.
REQ-025 sof & pix_valid in SCAN SHALL resync: counters restart at (0,0) for that pixel, pid_clear pulses that cycle, and pid_en=0 for that pixel.
REQ-026 DONE: res_valid=1, outputs held stable until res_valid & res_ready, then IDLE next cycle; a transfer in the first DONE cycle is legal.
REQ-027 start outside IDLE SHALL be ignored; pixels outside SCAN are dropped.

Reset
REQ-028 On rst=0, state=IDLE; every output and counter is 0 (pid_clear, pid_en, res_*, busy, pix_row, pix_col) immediately, independent of clk.
REQ-029 Reset mid-SCAN or mid-DONE SHALL discard the pending result; no res_valid after release until a new start.

Configuration
REQ-030 With PALM_SCAN_WATCHDOG_EN defined, a counter counts clocks without pix_valid in WAIT_SOF/SCAN; on reaching WDOG_CYCLES it goes to DONE with res_found=0, res_timeout=1; the counter clears on any pix_valid and on state entry.
REQ-031 Without PALM_SCAN_WATCHDOG_EN, res_timeout SHALL be tied 0, no watchdog logic exists, and WAIT_SOF/SCAN may wait indefinitely.

Structure
REQ-032 Shared package palm_pkg SHALL hold IMG_W, IMG_H, the WDOG_CYCLES default, and the FSM state enum.
REQ-033 Row/column counting SHALL be one sub-module, palm_pixel_counter (inputs: clear, inc; outputs: row, col, last).

Verification
REQ-034 start, sof at pixel 0, pid_found at row 10/col 40 with width 24/height 36 -> res_valid next cycle, res_found=1, res_width=24, res_height=36.
REQ-035 Full 160x120 frame, no pid_found -> DONE after pixel (119,159), res_found=0; col wraps 159->0 with row incrementing.
REQ-036 res_ready low for 5 cycles -> res_* stable, busy=1; ready high -> IDLE next cycle, busy=0.
REQ-037 sof again at row 50 in SCAN -> pid_clear pulse, pix_row/pix_col=0, pid_en=0 for that pixel.
REQ-038 Watchdog build, WDOG_CYCLES=16, pix_valid stalls 16 cycles -> res_timeout=1, res_found=0; non-watchdog build -> remains in SCAN.
REQ-039 rst low mid-SCAN -> all outputs 0 asynchronously, state IDLE; start during DONE ignored.
